ext_16_320: RTL and testbench

EXT_16_320 -- requirements
Module: ext_16_320

---
 rtl/ext_16_320.sv | 43 ++++
 tb/tb_ext_16_320.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ext_16_320.sv
// Immediate extender: combinational sign/zero extension, branch-offset shift and
// LUI forms, plus an optional one-cycle registered copy of the extended value.
module ext_16_320 #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] imm16,
  input  logic        sign,
  input  logic        in_valid,
  output logic [31:0] imm32,
  output logic [31:0] imm32_sl2,
  output logic [31:0] imm32_lui,
  output logic [31:0] q_imm32,
  output logic        q_valid
);

  logic [15:0] upper;

  assign upper     = (sign && imm16[15]) ? 16'hFFFF : 16'h0000;
  assign imm32     = {upper, imm16};
  assign imm32_sl2 = {imm32[29:0], 2'b00};
  assign imm32_lui = {imm16, 16'h0000};

  generate
    if (OUT_REG) begin : g_reg
      // q_imm32 only moves on valid input; q_valid simply tracks in_valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_imm32 <= 32'h0000_0000;
          q_valid <= 1'b0;
        end else begin
          q_valid <= in_valid;
          if (in_valid) q_imm32 <= imm32;
        end
      end
    end else begin : g_noreg
      assign q_imm32 = 32'h0000_0000;
      assign q_valid = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_ext_16_320.sv
// Self-checking bench for ext_16_320: directed vector table, exhaustive
// combinational sweep, hand-written register sequences and randomized traffic.
module tb_ext_16_320;

  logic        clk;
  logic        rst;
  logic [15:0] imm16;
  logic        sign;
  logic        in_valid;
  logic [31:0] imm32;
  logic [31:0] imm32_sl2;
  logic [31:0] imm32_lui;
  logic [31:0] q_imm32;
  logic        q_valid;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model_q;
  logic        model_v;

  typedef struct {
    logic [15:0] imm16;
    logic        sign;
    logic [31:0] exp_imm32;
    logic [31:0] exp_sl2;
    logic [31:0] exp_lui;
  } vec_t;

  vec_t vecs[8];

  ext_16_320 #(.OUT_REG(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .imm16(imm16),
    .sign(sign),
    .in_valid(in_valid),
    .imm32(imm32),
    .imm32_sl2(imm32_sl2),
    .imm32_lui(imm32_lui),
    .q_imm32(q_imm32),
    .q_valid(q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extension as integer value arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic s);
    longint val;
    logic [31:0] r;
    val = longint'(v);
    if (s && val >= 32768) val = val - 65536;
    r = 32'(val);
    return r;
  endfunction

  function automatic logic [31:0] ref_sl2(input logic [15:0] v, input logic s);
    longint p;
    logic [31:0] r;
    p = longint'(ref_ext(v, s)) * 4;
    r = 32'(p % 64'sd4294967296);
    return r;
  endfunction

  function automatic logic [31:0] ref_lui(input logic [15:0] v);
    logic [31:0] r;
    r = 32'(longint'(v) * 65536);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one registered-path cycle and advances the reference register.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d,
                               input logic s);
    @(negedge clk);
    rst = r;
    in_valid = v;
    imm16 = d;
    sign = s;
    if (r) begin
      model_q = 32'h0;
      model_v = 1'b0;
    end else begin
      model_v = v;
      if (v) model_q = ref_ext(d, s);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_ext;
    int bad_sl2;
    int bad_lui;
    logic r;
    logic v;
    logic [15:0] d;
    logic s;

    vecs[0] = '{16'hFFFC, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFC_0000};
    vecs[1] = '{16'hFFFC, 1'b0, 32'h0000_FFFC, 32'h0003_FFF0, 32'hFFFC_0000};
    vecs[2] = '{16'h7FFF, 1'b1, 32'h0000_7FFF, 32'h0001_FFFC, 32'h7FFF_0000};
    vecs[3] = '{16'h8000, 1'b1, 32'hFFFF_8000, 32'hFFFE_0000, 32'h8000_0000};
    vecs[4] = '{16'h0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{16'h8000, 1'b0, 32'h0000_8000, 32'h0002_0000, 32'h8000_0000};
    vecs[6] = '{16'h1234, 1'b1, 32'h0000_1234, 32'h0000_48D0, 32'h1234_0000};
    vecs[7] = '{16'hC001, 1'b1, 32'hFFFF_C001, 32'hFFFF_0004, 32'hC001_0000};

    // Reset with in_valid asserted: reset must win.
    rst = 1'b1;
    in_valid = 1'b1;
    imm16 = 16'h8001;
    sign = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_q_imm32", q_imm32, 32'h0);
    checkOutput("reset_q_valid", {31'b0, q_valid}, 32'h0);
    checkOutput("reset_comb_imm32", imm32, 32'hFFFF_8001);
    model_q = 32'h0;
    model_v = 1'b0;

    rst = 1'b0;
    in_valid = 1'b0;
    foreach (vecs[i]) begin
      imm16 = vecs[i].imm16;
      sign = vecs[i].sign;
      #1;
      checkOutput($sformatf("vec%0d_imm32", i), imm32, vecs[i].exp_imm32);
      checkOutput($sformatf("vec%0d_sl2", i), imm32_sl2, vecs[i].exp_sl2);
      checkOutput($sformatf("vec%0d_lui", i), imm32_lui, vecs[i].exp_lui);
    end

    // Exhaustive combinational sweep, tallied per sign value.
    for (int sv = 0; sv < 2; sv++) begin
      bad_ext = 0;
      bad_sl2 = 0;
      bad_lui = 0;
      for (int k = 0; k < 65536; k++) begin
        imm16 = 16'(k);
        sign = 1'(sv);
        #1;
        if (imm32 !== ref_ext(imm16, sign)) bad_ext++;
        if (imm32_sl2 !== ref_sl2(imm16, sign)) bad_sl2++;
        if (imm32_lui !== ref_lui(imm16)) bad_lui++;
      end
      checkOutput($sformatf("sweep_sign%0d_imm32_bad", sv), 32'(bad_ext), 32'h0);
      checkOutput($sformatf("sweep_sign%0d_sl2_bad", sv), 32'(bad_sl2), 32'h0);
      checkOutput($sformatf("sweep_sign%0d_lui_bad", sv), 32'(bad_lui), 32'h0);
    end

    // Load, then hold with in_valid low.
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1);
    checkOutput("load_q_imm32", q_imm32, 32'h0000_1234);
    checkOutput("load_q_valid", {31'b0, q_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 16'hBEEF, 1'b1);
    checkOutput("hold_q_imm32", q_imm32, 32'h0000_1234);
    checkOutput("hold_q_valid", {31'b0, q_valid}, 32'h0);

    // Mid-operation reset with in_valid high discards captured data.
    applyStimulus(1'b1, 1'b1, 16'h8001, 1'b1);
    checkOutput("midrst_q_imm32", q_imm32, 32'h0);
    checkOutput("midrst_q_valid", {31'b0, q_valid}, 32'h0);
    checkOutput("midrst_comb_imm32", imm32, 32'hFFFF_8001);
    applyStimulus(1'b0, 1'b0, 16'h5555, 1'b0);
    checkOutput("postrst_idle_q_imm32", q_imm32, 32'h0);
    applyStimulus(1'b0, 1'b1, 16'hFFFC, 1'b0);
    checkOutput("postrst_load_q_imm32", q_imm32, 32'h0000_FFFC);
    checkOutput("postrst_load_q_valid", {31'b0, q_valid}, 32'h1);

    // Randomized traffic against the reference register.
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 15) == 0);
      v = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      applyStimulus(r, v, d, s);
      checkOutput("rand_q_imm32", q_imm32, model_q);
      checkOutput("rand_q_valid", {31'b0, q_valid}, {31'b0, model_v});
      checkOutput("rand_imm32", imm32, ref_ext(d, s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
